// File: rtl/ddr_bus_monitor.sv
// ddr_bus_monitor: passive monitor of the DDR command/data bus. It tracks
// the open row of each bank and emits one packet per WRITE/READ access,
// built from the row and column captured at the command and dq sampled
// CWL/CL clocks after the command.
// Ports: clk, reset_n (async, active low); cs_n/ras_n/cas_n/we_n/ba/addr/dq
//   are the monitored bus; pkt_* is the packet stream (pkt_valid strobe);
//   cmd_err/bus_conflict are one-cycle error strobes; open_banks is the
//   per-bank open-row map.
module ddr_bus_monitor #(
    parameter int ROW_W  = 15,
    parameter int COL_W  = 10,
    parameter int DATA_W = 16,
    parameter int CWL    = 5,
    parameter int CL     = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [2:0]        ba,
    input  logic [ROW_W-1:0]  addr,
    input  logic [DATA_W-1:0] dq,
    output logic              pkt_valid,
    output logic              pkt_is_write,
    output logic [2:0]        pkt_bank,
    output logic [ROW_W-1:0]  pkt_row,
    output logic [COL_W-1:0]  pkt_col,
    output logic [DATA_W-1:0] pkt_data,
    output logic [31:0]       pkt_id,
    output logic              cmd_err,
    output logic              bus_conflict,
    output logic [7:0]        open_banks
);
    // One in-flight access: {bank, row, column}.
    localparam int EW = 3 + ROW_W + COL_W;

    logic act_c;
    logic pre_c;
    logic wr_c;
    logic rd_c;

    always_comb begin
        act_c = 1'b0;
        pre_c = 1'b0;
        wr_c  = 1'b0;
        rd_c  = 1'b0;
        if (!cs_n) begin
            unique case ({ras_n, cas_n, we_n})
                3'b011:  act_c = 1'b1;
                3'b010:  pre_c = 1'b1;
                3'b100:  wr_c  = 1'b1;
                3'b101:  rd_c  = 1'b1;
                default: ;
            endcase
        end
    end

    logic [7:0]       open_q;
    logic [7:0]       open_d;
    logic [ROW_W-1:0] row_q [8];
    logic             err_d;
    logic             hit_open;
    logic [EW-1:0]    acc_ent;

    assign hit_open = open_q[ba];
    assign acc_ent  = {ba, row_q[ba], addr[COL_W-1:0]};

    always_comb begin
        open_d = open_q;
        err_d  = 1'b0;
        if (act_c) begin
            if (hit_open) err_d = 1'b1;
            else          open_d[ba] = 1'b1;
        end
        if (pre_c) begin
            if (addr[10]) open_d = '0;
            else          open_d[ba] = 1'b0;
        end
        if ((wr_c || rd_c) && !hit_open) err_d = 1'b1;
    end

    // Latency pipelines: stage 0 loads at the command edge, so the last
    // stage is presented exactly at the dq sample edge.
    logic [CWL-1:0] wv_q;
    logic [EW-1:0]  wpe_q [CWL];
    logic [CL-1:0]  rv_q;
    logic [EW-1:0]  rpe_q [CL];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wv_q <= '0;
            rv_q <= '0;
            for (int i = 0; i < CWL; i++) wpe_q[i] <= '0;
            for (int i = 0; i < CL; i++)  rpe_q[i] <= '0;
        end else begin
            wv_q[0]  <= wr_c & hit_open;
            wpe_q[0] <= acc_ent;
            for (int i = 1; i < CWL; i++) begin
                wv_q[i]  <= wv_q[i-1];
                wpe_q[i] <= wpe_q[i-1];
            end
            rv_q[0]  <= rd_c & hit_open;
            rpe_q[0] <= acc_ent;
            for (int i = 1; i < CL; i++) begin
                rv_q[i]  <= rv_q[i-1];
                rpe_q[i] <= rpe_q[i-1];
            end
        end
    end

    logic          w_out;
    logic          r_out;
    logic [EW-1:0] out_ent;

    assign w_out   = wv_q[CWL-1];
    assign r_out   = rv_q[CL-1];
    assign out_ent = w_out ? wpe_q[CWL-1] : rpe_q[CL-1];

    logic              pkt_valid_q;
    logic              pkt_is_write_q;
    logic [2:0]        pkt_bank_q;
    logic [ROW_W-1:0]  pkt_row_q;
    logic [COL_W-1:0]  pkt_col_q;
    logic [DATA_W-1:0] pkt_data_q;
    logic [31:0]       pkt_id_q;
    logic [31:0]       id_cnt_q;
    logic              cmd_err_q;
    logic              conflict_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_q         <= '0;
            for (int i = 0; i < 8; i++) row_q[i] <= '0;
            pkt_valid_q    <= 1'b0;
            pkt_is_write_q <= 1'b0;
            pkt_bank_q     <= '0;
            pkt_row_q      <= '0;
            pkt_col_q      <= '0;
            pkt_data_q     <= '0;
            pkt_id_q       <= '0;
            id_cnt_q       <= '0;
            cmd_err_q      <= 1'b0;
            conflict_q     <= 1'b0;
        end else begin
            open_q      <= open_d;
            cmd_err_q   <= err_d;
            pkt_valid_q <= 1'b0;
            // Simultaneous write/read data is a collision: no packet, no id.
            conflict_q  <= w_out & r_out;
            if (act_c && !hit_open) row_q[ba] <= addr;
            if (w_out ^ r_out) begin
                pkt_valid_q    <= 1'b1;
                pkt_is_write_q <= w_out;
                {pkt_bank_q, pkt_row_q, pkt_col_q} <= out_ent;
                pkt_data_q     <= dq;
                pkt_id_q       <= id_cnt_q;
                id_cnt_q       <= id_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_valid    = pkt_valid_q;
    assign pkt_is_write = pkt_is_write_q;
    assign pkt_bank     = pkt_bank_q;
    assign pkt_row      = pkt_row_q;
    assign pkt_col      = pkt_col_q;
    assign pkt_data     = pkt_data_q;
    assign pkt_id       = pkt_id_q;
    assign cmd_err      = cmd_err_q;
    assign bus_conflict = conflict_q;
    assign open_banks   = open_q;

endmodule

// File: doc/ddr_bus_monitor.md
Name: ddr_bus_monitor

Overview:
- Passive monitor on the DDR-side command/data bus between the memory controller and the DDR model.
- Decodes ACTIVATE, PRECHARGE, WRITE and READ commands and tracks the open row per bank.
- Pairs each WRITE/READ with its data beat after the configured latency, then emits one packet per access: id, bank, row, column, data.
- Its packet outputs feed the end-of-test checker/scoreboard as the DDR-side packet stream.

Parameters:
- ROW_W, 15, row address width; addr bus width.
- COL_W, 10, column width, taken from addr[COL_W-1:0].
- DATA_W, 16, dq width and packet data width.
- CWL, 5, write latency in clocks, command edge to dq sample edge; legal 1..15.
- CL, 6, read latency in clocks, command edge to dq sample edge; legal 1..15.

Ports:
- clk  in  1  bus clock; all sampling on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select.
- ras_n  in  1  row strobe.
- cas_n  in  1  column strobe.
- we_n  in  1  write enable.
- ba  in  3  bank address.
- addr  in  ROW_W  row/column address; addr[10] is the all-banks bit on PRECHARGE.
- dq  in  DATA_W  data bus.
- pkt_valid  out  1  one-cycle strobe: packet fields valid.
- pkt_is_write  out  1  1 = WRITE packet, 0 = READ packet.
- pkt_bank  out  3  packet bank.
- pkt_row  out  ROW_W  packet row.
- pkt_col  out  COL_W  packet column.
- pkt_data  out  DATA_W  dq sampled for this access.
- pkt_id  out  32  packet sequence number.
- cmd_err  out  1  one-cycle strobe on an illegal command.
- bus_conflict  out  1  one-cycle strobe on a read/write data collision.
- open_banks  out  8  bit b = bank b has an open row.

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - All outputs 0.
  - All banks closed; stored rows cleared.
  - Both latency pipelines flushed.
  - id counter = 0.
- Reset asserted mid-operation discards all in-flight accesses; no packet is emitted for them.
- Command decode, each rising edge; cs_n=1 is a NOP. With cs_n=0, {ras_n,cas_n,we_n}:
  - 011 ACTIVATE.
  - 010 PRECHARGE.
  - 100 WRITE.
  - 101 READ.
  - All other encodings (NOP, REFRESH, MRS, ZQ, ...) are ignored.
- ACTIVATE:
  - Bank closed: store addr as the bank's row and set open_banks[ba] on the same edge.
  - Bank already open: cmd_err=1 next cycle; stored row unchanged.
- PRECHARGE:
  - addr[10]=1: close all banks.
  - addr[10]=0: close bank ba.
  - Precharging a closed bank is legal and silent.
- WRITE/READ to an open bank:
  - Push {bank, stored row, addr[COL_W-1:0]} into the write pipeline (depth CWL) or read pipeline (depth CL).
  - Each pipeline is a shift register with a valid bit per stage, one command per cycle maximum.
- WRITE/READ to a closed bank: cmd_err=1 next cycle; nothing pushed.
- Same-edge PRECHARGE and a later access: an access already pushed keeps its captured row. The pipeline is never modified by later commands.
- Emission:
  - Command sampled at edge k emerges at edge k+CWL (write) or k+CL (read).
  - dq is sampled at that edge.
  - Registered outputs give pkt_valid=1 for exactly the cycle following edge k+CWL/k+CL.
  - The other pkt_* fields hold their last values when pkt_valid=0.
- Collision: if a write and a read emerge at the same edge:
  - No packet for either.
  - bus_conflict=1 for one cycle.
  - The id counter does not advance.
- pkt_id:
  - Value of the id counter at emission; first packet after reset has id 0.
  - Counter increments by 1 per emitted packet and wraps 0xFFFFFFFF -> 0.
- Back-to-back accesses every cycle are supported: one packet per cycle, no stall, no loss.

Test Plan:
- Reset, ACT ba=2 row=0x1A3, then WRITE ba=2 col=0x040 at edge 10; dq=0xBEEF at edge 15 -> pkt_valid cycle after edge 15: is_write=1, bank=2, row=0x1A3, col=0x040, data=0xBEEF, id=0; open_banks=0x04.
- WRITE to closed bank 5 -> cmd_err one cycle, no packet; ACT bank 2 twice -> cmd_err on second, row unchanged.
- Four consecutive READs (bank 1 open), edges 20..23, dq 0x1111..0x4444 at edges 26..29 -> four packets, ids 0..3, consecutive cycles.
- WRITE at edge 31 and READ at edge 30 (both emerge at 36) -> bus_conflict one cycle, no packets; the next access still gets the next unused id.
- PRECHARGE addr[10]=1 the edge after a WRITE -> open_banks=0, the WRITE packet still emitted with the original row.
- Assert reset_n during a pending write -> outputs 0 immediately, no packet after release, next packet id=0.
